// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues word fetches, tracks up to two
// in-flight requests and buffers returned words for decode.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [31:0]              mem_rdata,
    output logic                     out_valid,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = CW + 1;

    logic              started_q;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [31:0]       instr_q [DEPTH];
    logic [31:0]       pc_q    [DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [31:0]       tag_pc_q [2];
    logic [1:0]        tag_drop_q, tag_drop_d;
    logic              tag_wptr_q, tag_wptr_d;
    logic              tag_rptr_q, tag_rptr_d;
    logic [1:0]        outs_q, outs_d;

    logic [OW-1:0]     occ;
    logic              can_req;
    logic              gnt;
    logic              rv;
    logic              push;
    logic              pop;
    logic              unused_rpc_lsbs;

    assign unused_rpc_lsbs = ^redirect_pc[1:0];

    // Handshake qualifiers: reserve queue space for every in-flight request
    always_comb begin
        occ     = {1'b0, count_q} + OW'(outs_q);
        can_req = started_q && (occ < OW'(DEPTH))
                  && (outs_q < 2'd2) && !redirect;
        gnt     = can_req && mem_gnt;
        rv      = mem_rvalid && (outs_q != 2'd0);
        push    = rv && !tag_drop_q[tag_rptr_q] && !redirect;
        pop     = (count_q != '0) && out_ready && !redirect;
    end

    // Next-state for pointers, counters, fetch PC and drop marks
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        tag_drop_d = tag_drop_q;
        tag_wptr_d = tag_wptr_q;
        tag_rptr_d = tag_rptr_q;
        outs_d     = outs_q + {1'b0, gnt} - {1'b0, rv};
        if (gnt) begin
            tag_wptr_d             = ~tag_wptr_q;
            tag_drop_d[tag_wptr_q] = 1'b0;
            fetch_pc_d             = fetch_pc_q + 32'd4;
        end
        if (rv) begin
            tag_rptr_d = ~tag_rptr_q;
        end
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
        if (redirect) begin
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            tag_drop_d = 2'b11;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            started_q  <= 1'b0;
            fetch_pc_q <= RESET_PC;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            tag_drop_q <= '0;
            tag_wptr_q <= 1'b0;
            tag_rptr_q <= 1'b0;
            outs_q     <= '0;
        end else begin
            started_q  <= 1'b1;
            fetch_pc_q <= fetch_pc_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            tag_drop_q <= tag_drop_d;
            tag_wptr_q <= tag_wptr_d;
            tag_rptr_q <= tag_rptr_d;
            outs_q     <= outs_d;
        end
    end

    // Tag FIFO remembers the PC of each granted request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                tag_pc_q[i] <= '0;
            end
        end else if (gnt) begin
            tag_pc_q[tag_wptr_q] <= fetch_pc_q;
        end
    end

    // Queue storage written at the tail on accepted responses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else if (push) begin
            instr_q[wptr_q] <= mem_rdata;
            pc_q[wptr_q]    <= tag_pc_q[tag_rptr_q];
        end
    end

    assign mem_req   = can_req;
    assign mem_addr  = fetch_pc_q;
    assign out_valid = (count_q != '0);
    assign out_instr = instr_q[rptr_q];
    assign out_pc    = pc_q[rptr_q];
    assign count     = count_q;

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, which sets the number of queue entries; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port redirect, input, 1 bit: a taken branch or jump; flushes the queue.
REQ-006 The block SHALL have port redirect_pc, input, 32 bits: the new fetch address; bits [1:0] are ignored and treated as 0.
REQ-007 The block SHALL have port mem_req, output, 1 bit: an instruction-memory read request.
REQ-008 The block SHALL have port mem_addr, output, 32 bits: the word-aligned read address, valid while mem_req is high.
REQ-009 The block SHALL have port mem_gnt, input, 1 bit: memory accepts the request in the cycle mem_req and mem_gnt are both high.
REQ-010 The block SHALL have port mem_rvalid, input, 1 bit: read data returning; responses come back in order, at least 1 cycle after grant.
REQ-011 The block SHALL have port mem_rdata, input, 32 bits: the instruction word, valid with mem_rvalid.
REQ-012 The block SHALL have port out_valid, output, 1 bit: the queue head is valid.
REQ-013 The block SHALL have port out_instr, output, 32 bits: the head instruction word.
REQ-014 The block SHALL have port out_pc, output, 32 bits: the address the head word was fetched from.
REQ-015 The block SHALL have port out_ready, input, 1 bit: the decode stage consumes the head; a pop occurs when out_valid and out_ready are both high.
REQ-016 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: the number of valid entries.

Function
REQ-017 The block SHALL keep a fetch_pc register that advances by 4 on every grant (mod 2^32; 32'hFFFF_FFFC wraps to 0).
REQ-018 The block SHALL allow at most 2 outstanding requests (granted, response not yet received).
REQ-019 The block SHALL assert mem_req only when all of the following hold:
- count + outstanding < DEPTH;
- outstanding < 2;
- redirect is low.
REQ-020 The block SHALL drive mem_addr = fetch_pc at all times.
REQ-021 While mem_req is high and mem_gnt is low, the block SHALL hold mem_req and mem_addr stable.
REQ-022 The block SHALL track the PC of each outstanding request in a 2-entry in-order tag FIFO; on each mem_rvalid, the response is written to the queue tail as {mem_rdata, tag PC}.
REQ-023 The block SHALL present the head combinationally from registered storage; out_valid = (count != 0).
REQ-024 Push and pop in the same cycle SHALL be allowed in any state, including full; count is then unchanged.
REQ-025 Empty state: out_valid = 0, and out_ready is ignored.
REQ-026 Full state: the space reservation in REQ-019 guarantees a push never overflows; a push that would overflow is a bench assertion failure.
REQ-027 When redirect is high, the following SHALL take effect on the next edge:
- count = 0 and the queue pointers are cleared;
- fetch_pc = {redirect_pc[31:2], 2'b00};
- every outstanding request is marked drop.
REQ-028 In a redirect cycle, redirect SHALL have priority: a simultaneous pop and a simultaneous mem_rvalid push are discarded.
REQ-029 The block SHALL discard responses to drop-marked requests and decrement outstanding for them without pushing.
REQ-030 New requests SHALL be issued after a redirect even while dropped responses are still pending; the 2-outstanding limit includes dropped requests.
REQ-031 Latency SHALL be: a response received at edge N gives out_valid high after edge N, and out_valid on an empty queue is visible at the earliest in the cycle after mem_rvalid.
REQ-032 If mem_rvalid arrives with outstanding == 0, the block SHALL ignore it.

Reset
REQ-033 When rst is low, the block SHALL asynchronously set:
- count = 0, out_valid = 0;
- fetch_pc = RESET_PC;
- outstanding = 0 and all drop marks cleared;
- mem_req = 0.
REQ-034 out_instr and out_pc SHALL be 0 during reset.
REQ-035 The first mem_req SHALL assert no earlier than the first rising edge after rst deasserts.
REQ-036 A reset asserted mid-operation SHALL abandon in-flight responses; the memory model is reset together with the block.

Verification
REQ-037 Streaming: memory always grants, 1-cycle latency, out_ready = 1 -> pops return PCs 0x0, 0x4, 0x8, 0xC in order, with instr equal to the memory image.
REQ-038 Backpressure: out_ready = 0 for 20 cycles -> count saturates at 4, mem_req is low, and exactly 4 grants occur; releasing out_ready yields PCs 0x0 through 0xC with no gap or duplicate.
REQ-039 Redirect with 2 outstanding (3-cycle latency): redirect_pc = 0x100 -> both late responses are dropped, and the next popped PC is 0x100.
REQ-040 Simultaneous events: redirect coinciding with a pop and with mem_rvalid -> count = 0 on the next cycle, and the following pop is PC 0x100.
REQ-041 Wrap and alignment: redirect_pc = 32'hFFFF_FFFA -> fetches 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0000_0000.
REQ-042 Reset mid-stream: rst low with count = 3 -> out_valid = 0 and count = 0 immediately; after release, the first mem_addr is RESET_PC.
